// File: rtl/quad_decoder_if.sv
// Encoder inputs, controls and step/dir/count/err outputs of quad_decoder.
// The master side is the decoder; the slave side is the counter or bench that consumes step/dir.
interface quad_decoder_if #(
   parameter int WIDTH = 3
);
   logic             a_in;
   logic             b_in;
   logic             clear;
   logic             err_clr;
   logic             step;
   logic             dir;
   logic [WIDTH-1:0] count;
   logic             err;

   modport master (
      input  a_in, b_in, clear, err_clr,
      output step, dir, count, err
   );

   modport slave (
      output a_in, b_in, clear, err_clr,
      input  step, dir, count, err
   );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder with step/dir pulses, wrapping count and a sticky err flag; QDEC_GLITCH_FILTER_EN adds an input filter.
// Latency: 3 edges from input change to step, plus FILTER_LEN edges with the filter. No backpressure: step is a 1-cycle pulse.
module quad_decoder #(
   parameter int WIDTH      = 3,
   parameter int FILTER_LEN = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   quad_decoder_if.master bus
);

   if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
      $error("quad_decoder: FILTER_LEN must be in 1..15");
   end

   // Phase vectors are {A,B}
   logic [1:0] sync1_q, sync1_d;
   logic [1:0] sync2_q, sync2_d;
   logic [1:0] vld_q, vld_d;
   logic [1:0] ph;
   logic       ph_vld;

   always_comb begin
      sync1_d = {bus.a_in, bus.b_in};
      sync2_d = sync1_q;
      vld_d   = {vld_q[0], 1'b1};
   end

`ifdef QDEC_GLITCH_FILTER_EN
   localparam logic [3:0] FLT_LAST = 4'(FILTER_LEN - 1);

   logic [1:0] flt_q, flt_d;
   logic       flt_vld_q, flt_vld_d;
   logic [3:0] fcnt_q [2];
   logic [3:0] fcnt_d [2];

   // The filter is seeded from the first valid synchronized sample so a static level is never seen as a change
   always_comb begin
      flt_d     = flt_q;
      flt_vld_d = flt_vld_q;
      for (int i = 0; i < 2; i++) begin
         fcnt_d[i] = 4'd0;
      end
      if (!flt_vld_q) begin
         if (vld_q[1]) begin
            flt_d     = sync2_q;
            flt_vld_d = 1'b1;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != flt_q[i]) begin
               if (fcnt_q[i] == FLT_LAST) begin
                  flt_d[i] = sync2_q[i];
               end else begin
                  fcnt_d[i] = fcnt_q[i] + 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flt_q     <= 2'b00;
         flt_vld_q <= 1'b0;
         fcnt_q[0] <= 4'd0;
         fcnt_q[1] <= 4'd0;
      end else begin
         flt_q     <= flt_d;
         flt_vld_q <= flt_vld_d;
         fcnt_q[0] <= fcnt_d[0];
         fcnt_q[1] <= fcnt_d[1];
      end
   end

   assign ph     = flt_q;
   assign ph_vld = flt_vld_q;
`else
   assign ph     = sync2_q;
   assign ph_vld = vld_q[1];
`endif

   // Position of a phase along the up sequence 00,10,11,01
   function automatic logic [1:0] gidx(input logic [1:0] p);
      return {p[0], p[1] ^ p[0]};
   endfunction

   logic             step_q, step_d;
   logic             dir_q, dir_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             err_q, err_d;
   logic [1:0]       prev_q, prev_d;
   logic             primed_q, primed_d;
   logic [1:0]       delta;

   always_comb begin
      delta    = gidx(ph) - gidx(prev_q);
      step_d   = 1'b0;
      dir_d    = dir_q;
      count_d  = count_q;
      err_d    = bus.err_clr ? 1'b0 : err_q;
      prev_d   = prev_q;
      primed_d = primed_q | ph_vld;
      if (!primed_q) begin
         if (ph_vld) begin
            prev_d = ph;
         end
      end else if (ph != prev_q) begin
         prev_d = ph;
         case (delta)
            2'd1: begin
               step_d  = 1'b1;
               dir_d   = 1'b1;
               count_d = count_q + WIDTH'(1);
            end
            2'd3: begin
               step_d  = 1'b1;
               dir_d   = 1'b0;
               count_d = count_q - WIDTH'(1);
            end
            default: err_d = 1'b1;
         endcase
      end
      if (bus.clear) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 2'b00;
         sync2_q  <= 2'b00;
         vld_q    <= 2'b00;
         step_q   <= 1'b0;
         dir_q    <= 1'b1;
         count_q  <= '0;
         err_q    <= 1'b0;
         prev_q   <= 2'b00;
         primed_q <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         vld_q    <= vld_d;
         step_q   <= step_d;
         dir_q    <= dir_d;
         count_q  <= count_d;
         err_q    <= err_d;
         prev_q   <= prev_d;
         primed_q <= primed_d;
      end
   end

   assign bus.step  = step_q;
   assign bus.dir   = dir_q;
   assign bus.count = count_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder: expected step records are queued with the stimulus and popped by a monitor on every step.
module tb_quad_decoder;

   localparam int WIDTH = 3;
   localparam int FLEN  = 2;
`ifdef QDEC_GLITCH_FILTER_EN
   localparam int LAT = 3 + FLEN;
`else
   localparam int LAT = 3;
`endif

   typedef struct packed {
      logic             dir;
      logic [WIDTH-1:0] count;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_tot  = 0;
   int   n_pass = 0;
   exp_t sb[$];
   exp_t mon_e;

   quad_decoder_if #(.WIDTH(WIDTH)) bus ();

   quad_decoder #(.WIDTH(WIDTH), .FILTER_LEN(FLEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive a phase and hold it LAT+1 cycles; clear/err_clr are asserted on the edge that decodes it
   task automatic move(input logic [1:0] ph, input bit exp_step, input logic edir,
                       input logic [WIDTH-1:0] ecnt, input bit do_clr, input bit do_eclr);
      if (exp_step) sb.push_back('{dir: edir, count: ecnt});
      @(negedge clk);
      {bus.a_in, bus.b_in} = ph;
      repeat (LAT - 1) @(negedge clk);
      bus.clear   = do_clr;
      bus.err_clr = do_eclr;
      @(negedge clk);
      bus.clear   = 1'b0;
      bus.err_clr = 1'b0;
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.step === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_step", {31'b0, bus.step}, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("step_dir", {31'b0, bus.dir}, {31'b0, mon_e.dir});
            chk("step_count", {29'b0, bus.count}, {29'b0, mon_e.count});
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [1:0]       up_ph  [9] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10};
   logic [WIDTH-1:0] up_cnt [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};

   initial begin
      bus.a_in    = 1'b1;
      bus.b_in    = 1'b1;
      bus.clear   = 1'b0;
      bus.err_clr = 1'b0;
      rst_n       = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_step", {31'b0, bus.step}, 32'd0);
      chk("rst_dir", {31'b0, bus.dir}, 32'd1);
      chk("rst_count", {29'b0, bus.count}, 32'd0);
      chk("rst_err", {31'b0, bus.err}, 32'd0);

      // Static 11 after release: no step, no err
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("idle_err", {31'b0, bus.err}, 32'd0);
      chk("idle_count", {29'b0, bus.count}, 32'd0);
      chk("idle_dir", {31'b0, bus.dir}, 32'd1);

      move(2'b01, 1, 1'b1, 3'd1, 0, 0);
      move(2'b00, 1, 1'b1, 3'd2, 0, 0);
      @(negedge clk);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      chk("clear_count", {29'b0, bus.count}, 32'd0);

      for (int i = 0; i < 9; i++) begin
         move(up_ph[i], 1, 1'b1, up_cnt[i], 0, 0);
      end
      chk("up_count", {29'b0, bus.count}, 32'd1);
      move(2'b00, 1, 1'b0, 3'd0, 0, 0);
      move(2'b01, 1, 1'b0, 3'd7, 0, 0);
      chk("down_count", {29'b0, bus.count}, 32'd7);
      chk("down_dir", {31'b0, bus.dir}, 32'd0);

      move(2'b00, 1, 1'b1, 3'd0, 0, 0);
      move(2'b11, 0, 1'b0, 3'd0, 0, 0);
      chk("jump_err", {31'b0, bus.err}, 32'd1);
      chk("jump_count", {29'b0, bus.count}, 32'd0);
      chk("jump_dir", {31'b0, bus.dir}, 32'd1);
      move(2'b00, 0, 1'b0, 3'd0, 0, 1);
      chk("errclr_vs_set", {31'b0, bus.err}, 32'd1);
      @(negedge clk);
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
      chk("errclr_alone", {31'b0, bus.err}, 32'd0);

      move(2'b10, 1, 1'b1, 3'd0, 1, 0);
      chk("clear_with_step", {29'b0, bus.count}, 32'd0);
      move(2'b11, 1, 1'b1, 3'd1, 0, 0);

      // One-cycle low pulse on A: two back-to-back steps unfiltered, nothing when filtered
`ifndef QDEC_GLITCH_FILTER_EN
      sb.push_back('{dir: 1'b1, count: 3'd2});
      sb.push_back('{dir: 1'b0, count: 3'd1});
`endif
      @(negedge clk);
      bus.a_in = 1'b0;
      @(negedge clk);
      bus.a_in = 1'b1;
      repeat (LAT + 2) @(negedge clk);
      chk("glitch_count", {29'b0, bus.count}, 32'd1);
      chk("glitch_err", {31'b0, bus.err}, 32'd0);

      sb.push_back('{dir: 1'b1, count: 3'd2});
      bus.a_in = 1'b0;
      repeat (LAT - 1) @(negedge clk);
      chk("latency_early", {31'b0, bus.step}, 32'd0);
      @(negedge clk);
      chk("latency_step", {31'b0, bus.step}, 32'd1);
      @(negedge clk);
      chk("step_one_cycle", {31'b0, bus.step}, 32'd0);

      move(2'b00, 1, 1'b1, 3'd3, 0, 0);
      move(2'b10, 1, 1'b1, 3'd4, 0, 0);
      move(2'b11, 1, 1'b1, 3'd5, 0, 0);
      move(2'b00, 0, 1'b0, 3'd0, 0, 0);
      chk("pre_rst_count", {29'b0, bus.count}, 32'd5);
      chk("pre_rst_err", {31'b0, bus.err}, 32'd1);

      // Asynchronous reset between clock edges
      bus.a_in = 1'b1;
      bus.b_in = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_count", {29'b0, bus.count}, 32'd0);
      chk("arst_err", {31'b0, bus.err}, 32'd0);
      chk("arst_step", {31'b0, bus.step}, 32'd0);
      chk("arst_dir", {31'b0, bus.dir}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("post_rst_count", {29'b0, bus.count}, 32'd0);
      chk("post_rst_err", {31'b0, bus.err}, 32'd0);

      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
